// File: rtl/cp0_regfile_if.sv
// MFC0/MTC0 access bus of the CP0 register bank.
// The master side is the pipeline (MEM/WB); the slave side is cp0_regfile.
interface cp0_regfile_if;
  logic [4:0]  rd_i;
  logic [2:0]  sel_i;
  logic        rd_en_i;
  logic [31:0] rdata_o;
  logic        wr_en_i;
  logic [31:0] wdata_i;
  logic        illegal_o;

  modport master (
    output rd_i, sel_i, rd_en_i, wr_en_i, wdata_i,
    input  rdata_o, illegal_o
  );

  modport slave (
    input  rd_i, sel_i, rd_en_i, wr_en_i, wdata_i,
    output rdata_o, illegal_o
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS32 Coprocessor-0 register bank: MFC0/MTC0 access, exception/ERET state,
// interrupt request and redirect vector generation.
// Optional feature macro: CP0_TIMER_EN (free-running Count with Compare match -> Cause.TI).
module cp0_regfile #(
  parameter int unsigned NUM_HW_INT = 6,
  parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
  parameter logic [31:0] EBASE_RST  = 32'h8000_0000,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cp0_regfile_if.slave          bus,
  input  logic [NUM_HW_INT-1:0] hw_int_i,
  input  logic                  exc_req_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badva_i,
  input  logic                  eret_i,
  output logic                  exc_taken_o,
  output logic [31:0]           vector_o,
  output logic                  irq_o
);

  localparam logic [7:0]  AddrBadva   = {5'd8, 3'd0};
  localparam logic [7:0]  AddrCount   = {5'd9, 3'd0};
  localparam logic [7:0]  AddrCompare = {5'd11, 3'd0};
  localparam logic [7:0]  AddrStatus  = {5'd12, 3'd0};
  localparam logic [7:0]  AddrCause   = {5'd13, 3'd0};
  localparam logic [7:0]  AddrEpc     = {5'd14, 3'd0};
  localparam logic [7:0]  AddrPrid    = {5'd15, 3'd0};
  localparam logic [7:0]  AddrEbase   = {5'd15, 3'd1};
  localparam logic [31:0] StatusWmask = 32'h0000_FF03;
  localparam logic [31:0] EbaseWmask  = 32'h3FFF_F000;
  localparam logic [31:0] BootVector  = 32'hBFC0_0380;

  // Architectural state
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badva_q, badva_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] ebase_q, ebase_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [4:0]  code_q, code_d;
  logic [1:0]  sw_ip_q, sw_ip_d;
  logic [5:0]  hw_ip_q, hw_ip_d;     // Cause.IP[7:2]

  // Registered outputs
  logic [31:0] rdata_q, rdata_d;
  logic        illegal_q, illegal_d;
  logic        taken_q, taken_d;
  logic [31:0] vector_q, vector_d;
  logic        irq_q, irq_d;

  logic [7:0]  addr;
  logic        implemented;
  logic        wr_eff;
  logic [7:0]  ip_cur;
  logic [31:0] cause_val;
  logic [31:0] read_val;

  assign addr   = {bus.rd_i, bus.sel_i};
  // A write that collides with an exception or ERET is dropped entirely.
  assign wr_eff = bus.wr_en_i & ~exc_req_i & ~eret_i;

  // Timer interrupt shares IP[7] with the highest hardware line.
  assign ip_cur    = {hw_ip_q[5] | ti_q, hw_ip_q[4:0], sw_ip_q};
  assign cause_val = {bd_q, ti_q, 14'b0, ip_cur, 1'b0, code_q, 2'b00};

  // Register map decode and MFC0 read mux (current, pre-write values)
  always_comb begin
    implemented = 1'b1;
    read_val    = 32'h0;
    case (addr)
      AddrBadva:   read_val = badva_q;
      AddrCount:   read_val = count_q;
      AddrCompare: read_val = compare_q;
      AddrStatus:  read_val = status_q;
      AddrCause:   read_val = cause_val;
      AddrEpc:     read_val = epc_q;
      AddrPrid:    read_val = PRID_VAL;
      AddrEbase:   read_val = ebase_q;
      default:     implemented = 1'b0;
    endcase
  end

  // Next state: exception > ERET > MTC0, plus interrupt sampling and timer
  always_comb begin
    status_d  = status_q;
    epc_d     = epc_q;
    badva_d   = badva_q;
    ebase_d   = ebase_q;
    bd_d      = bd_q;
    code_d    = code_q;
    sw_ip_d   = sw_ip_q;
    hw_ip_d   = '0;
    hw_ip_d[NUM_HW_INT-1:0] = hw_int_i;
`ifdef CP0_TIMER_EN
    count_d   = count_q + 32'd1;
`else
    count_d   = count_q;
`endif
    compare_d = compare_q;
    taken_d   = exc_req_i | eret_i;
    vector_d  = 32'h0;

    if (exc_req_i) begin
      // Nested exceptions keep the original EPC/BD.
      if (!status_q[1]) begin
        epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
        bd_d  = exc_bd_i;
      end
      status_d[1] = 1'b1;
      code_d      = exc_code_i;
      if (exc_code_i == 5'd4 || exc_code_i == 5'd5) badva_d = exc_badva_i;
      vector_d = status_q[22] ? BootVector : {ebase_q[31:12], 12'h180};
    end else if (eret_i) begin
      status_d[1] = 1'b0;
      vector_d    = epc_q;
    end else if (bus.wr_en_i) begin
      case (addr)
        AddrCount:   count_d   = bus.wdata_i;
        AddrCompare: compare_d = bus.wdata_i;
        AddrStatus:  status_d  = (status_q & ~StatusWmask) | (bus.wdata_i & StatusWmask);
        AddrCause:   sw_ip_d   = bus.wdata_i[9:8];
        AddrEpc:     epc_d     = bus.wdata_i;
        AddrEbase:   ebase_d   = (ebase_q & ~EbaseWmask) | (bus.wdata_i & EbaseWmask);
        default:     ;
      endcase
    end

`ifdef CP0_TIMER_EN
    // Compare write clears TI and wins over a simultaneous match.
    if (wr_eff && addr == AddrCompare) ti_d = 1'b0;
    else if (count_d == compare_d)     ti_d = 1'b1;
    else                               ti_d = ti_q;
`else
    ti_d = 1'b0;
`endif

    illegal_d = ~implemented & (bus.rd_en_i | wr_eff);
    rdata_d   = bus.rd_en_i ? read_val : rdata_q;
    irq_d     = status_q[0] & ~status_q[1] & (|(ip_cur & status_q[15:8]));
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q  <= STATUS_RST;
      epc_q     <= 32'h0;
      badva_q   <= 32'h0;
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      ebase_q   <= EBASE_RST;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      code_q    <= 5'h0;
      sw_ip_q   <= 2'b0;
      hw_ip_q   <= 6'b0;
      rdata_q   <= 32'h0;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
      vector_q  <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      status_q  <= status_d;
      epc_q     <= epc_d;
      badva_q   <= badva_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ebase_q   <= ebase_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      code_q    <= code_d;
      sw_ip_q   <= sw_ip_d;
      hw_ip_q   <= hw_ip_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
      taken_q   <= taken_d;
      vector_q  <= vector_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.rdata_o   = rdata_q;
  assign bus.illegal_o = illegal_q;
  assign exc_taken_o   = taken_q;
  assign vector_o      = vector_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized + directed bench for cp0_regfile against a register-level reference model.
module tb_cp0_regfile;
  localparam int NHW = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NHW-1:0] hw_int = '0;
  logic           exc_req = 1'b0;
  logic [4:0]     exc_code = '0;
  logic [31:0]    exc_pc = '0;
  logic           exc_bd = 1'b0;
  logic [31:0]    exc_badva = '0;
  logic           eret = 1'b0;
  logic           exc_taken;
  logic [31:0]    vector;
  logic           irq;

  cp0_regfile_if bus ();

  cp0_regfile #(.NUM_HW_INT(NHW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .hw_int_i    (hw_int),
    .exc_req_i   (exc_req),
    .exc_code_i  (exc_code),
    .exc_pc_i    (exc_pc),
    .exc_bd_i    (exc_bd),
    .exc_badva_i (exc_badva),
    .eret_i      (eret),
    .exc_taken_o (exc_taken),
    .vector_o    (vector),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
  endtask

  // Reference model: named architectural registers
  logic [31:0] m_status, m_epc, m_badva, m_count, m_compare, m_ebase;
  logic        m_bd, m_ti;
  logic [4:0]  m_code;
  logic [1:0]  m_swip;
  logic [7:0]  m_hwip;
  logic [31:0] e_rdata;
  logic        e_illegal, e_taken, e_irq;
  logic [31:0] e_vector;

  task automatic model_reset();
    m_status = 32'h0040_0000; m_epc = 0; m_badva = 0; m_count = 0; m_compare = 0;
    m_ebase = 32'h8000_0000; m_bd = 0; m_ti = 0; m_code = 0; m_swip = 0; m_hwip = 0;
    e_rdata = 0; e_illegal = 0; e_taken = 0; e_irq = 0; e_vector = 0;
  endtask

  function automatic logic [7:0] m_ip();
    return {m_hwip[7] | m_ti, m_hwip[6:2], m_swip};
  endfunction

  function automatic bit m_impl(input logic [4:0] r, input logic [2:0] s);
    if (s == 0) return (r == 8 || r == 9 || r == 11 || r == 12 || r == 13 || r == 14 || r == 15);
    return (r == 15 && s == 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
    if (!m_impl(r, s)) return 32'h0;
    if (r == 15) return (s == 1) ? m_ebase : 32'h0001_8000;
    case (r)
      8:  return m_badva;
      9:  return m_count;
      11: return m_compare;
      12: return m_status;
      13: return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b00};
      default: return m_epc;
    endcase
  endfunction

  // One clock: predict from pre-edge state and inputs, advance the model, compare after the edge
  task automatic tick();
    logic [4:0]  r;
    logic [2:0]  s;
    logic [31:0] w, nc, ncmp;
    bit wr, did_rd;
    r = bus.rd_i; s = bus.sel_i; w = bus.wdata_i;
    wr = bus.wr_en_i && !exc_req && !eret;
    did_rd = bus.rd_en_i;
    if (did_rd) e_rdata = m_read(r, s);
    e_illegal = !m_impl(r, s) && (did_rd || wr);
    e_irq = m_status[0] && !m_status[1] && (|(m_ip() & m_status[15:8]));
    e_taken = exc_req || eret;
    e_vector = 0;
`ifdef CP0_TIMER_EN
    nc = m_count + 1;
`else
    nc = m_count;
`endif
    ncmp = m_compare;
    if (exc_req) begin
      e_vector = m_status[22] ? 32'hBFC0_0380 : {m_ebase[31:12], 12'h180};
      if (!m_status[1]) begin
        m_epc = exc_bd ? exc_pc - 4 : exc_pc;
        m_bd = exc_bd;
      end
      m_status[1] = 1'b1;
      m_code = exc_code;
      if (exc_code == 4 || exc_code == 5) m_badva = exc_badva;
    end else if (eret) begin
      e_vector = m_epc;
      m_status[1] = 1'b0;
    end else if (wr && s == 0) begin
      case (r)
        9:  nc = w;
        11: ncmp = w;
        12: m_status = {m_status[31:16], w[15:8], m_status[7:2], w[1:0]};
        13: m_swip = w[9:8];
        14: m_epc = w;
        default: ;
      endcase
    end else if (wr && r == 15 && s == 1) begin
      m_ebase = {m_ebase[31:30], w[29:12], 12'h000};
    end
`ifdef CP0_TIMER_EN
    if (wr && r == 11 && s == 0) m_ti = 0;
    else if (nc == ncmp) m_ti = 1;
`endif
    m_count = nc; m_compare = ncmp;
    m_hwip = {hw_int, 2'b00};
    @(posedge clk); #1;
    check("exc_taken", {31'b0, exc_taken}, {31'b0, e_taken});
    check("irq", {31'b0, irq}, {31'b0, e_irq});
    check("illegal", {31'b0, bus.illegal_o}, {31'b0, e_illegal});
    if (e_taken) check("vector", vector, e_vector);
    if (did_rd) check("rdata", bus.rdata_o, e_rdata);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [2:0] s, input logic [31:0] d);
    bus.rd_i = r; bus.sel_i = s; bus.wdata_i = d; bus.wr_en_i = 1;
    tick();
    bus.wr_en_i = 0;
  endtask

  task automatic mfc0(input logic [4:0] r, input logic [2:0] s);
    bus.rd_i = r; bus.sel_i = s; bus.rd_en_i = 1;
    tick();
    bus.rd_en_i = 0;
  endtask

  task automatic raise_exc(input logic [4:0] c, input logic [31:0] pc, input logic bd,
                           input logic [31:0] bva);
    exc_req = 1; exc_code = c; exc_pc = pc; exc_bd = bd; exc_badva = bva;
    tick();
    exc_req = 0;
  endtask

  initial begin
    bus.rd_i = 0; bus.sel_i = 0; bus.rd_en_i = 0; bus.wr_en_i = 0; bus.wdata_i = 0;
    model_reset();
    #12;
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_taken", {31'b0, exc_taken}, 32'h0);
    check("rst_vector", vector, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;

    // Status write masking and illegal access
    mfc0(12, 0);
    check("status_rst", bus.rdata_o, 32'h0040_0000);
    mtc0(12, 0, 32'hFFFF_FFFF);
    mfc0(12, 0);
    check("status_mask", bus.rdata_o, 32'h0040_FF03);
    mtc0(7, 0, 32'h1234_5678);
    check("illegal_wr", {31'b0, bus.illegal_o}, 32'h1);
    mfc0(7, 0);
    check("illegal_rd", bus.rdata_o, 32'h0);
    mfc0(15, 0);
    check("prid", bus.rdata_o, 32'h0001_8000);
    mtc0(12, 0, 32'h0);

    // Exception in a delay slot with an address error
    raise_exc(4, 32'h8000_0104, 1, 32'h1233);
    check("exc_vec_bev", vector, 32'hBFC0_0380);
    mfc0(14, 0);
    check("epc_bd", bus.rdata_o, 32'h8000_0100);
    mfc0(13, 0);
    check("cause_exc", bus.rdata_o, 32'h8000_0010);
    mfc0(8, 0);
    check("badva", bus.rdata_o, 32'h0000_1233);

    // Nested exception keeps EPC; ERET returns to it
    raise_exc(0, 32'h8000_0200, 0, 32'h0);
    mfc0(14, 0);
    check("epc_nested", bus.rdata_o, 32'h8000_0100);
    eret = 1; tick(); eret = 0;
    check("eret_vec", vector, 32'h8000_0100);
    mfc0(12, 0);
    check("exl_clr", {31'b0, bus.rdata_o[1]}, 32'h0);

    // Interrupt path and exception-vs-ERET priority
    mtc0(12, 0, 32'h0000_0401);
    hw_int[0] = 1;
    tick();
    check("irq_lat1", {31'b0, irq}, 32'h0);
    tick();
    check("irq_lat2", {31'b0, irq}, 32'h1);
    exc_req = 1; eret = 1; exc_code = 5'd8; exc_pc = 32'h8000_0300; exc_bd = 0;
    tick();
    exc_req = 0; eret = 0;
    mfc0(12, 0);
    check("exc_beats_eret", {31'b0, bus.rdata_o[1]}, 32'h1);
    hw_int = '0;
    mtc0(12, 0, 32'h0);

`ifdef CP0_TIMER_EN
    // Count wrap and Compare match
    mtc0(9, 0, 32'hFFFF_FFFE);
    mtc0(11, 0, 32'h1);
    repeat (3) tick();
    mfc0(13, 0);
    check("ti_set", {31'b0, bus.rdata_o[30]}, 32'h1);
    mtc0(11, 0, 32'h1000_0000);
    mfc0(13, 0);
    check("ti_clr", {31'b0, bus.rdata_o[30]}, 32'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 7) begin
        bus.rd_i = 5'($urandom_range(8, 15));
        bus.sel_i = 3'($urandom_range(0, 1));
      end else begin
        bus.rd_i = 5'($urandom);
        bus.sel_i = 3'($urandom);
      end
      bus.rd_en_i = ($urandom_range(0, 1) == 1);
      bus.wr_en_i = ($urandom_range(0, 2) == 0);
      bus.wdata_i = $urandom;
      exc_req = ($urandom_range(0, 15) == 0);
      eret = ($urandom_range(0, 11) == 0);
      exc_code = 5'($urandom_range(0, 7));
      exc_pc = $urandom;
      exc_bd = 1'($urandom);
      exc_badva = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = NHW'($urandom);
      tick();
    end
    bus.rd_en_i = 0; bus.wr_en_i = 0; exc_req = 0; eret = 0; hw_int = '0;
    tick();

    // Reset while an exception pulse is pending
    exc_req = 1; exc_code = 5'd4; exc_pc = 32'h8000_0400; exc_badva = 32'hDEAD_0000;
    #2; rst_n = 0;
    @(posedge clk); #1;
    exc_req = 0;
    check("rst_mid_taken", {31'b0, exc_taken}, 32'h0);
    check("rst_mid_vector", vector, 32'h0);
    check("rst_mid_irq", {31'b0, irq}, 32'h0);
    model_reset();
    rst_n = 1;
    mfc0(12, 0);
    check("rst_status", bus.rdata_o, 32'h0040_0000);
    mfc0(14, 0);
    check("rst_epc", bus.rdata_o, 32'h0);
    mfc0(8, 0);
    check("rst_badva", bus.rdata_o, 32'h0);
    mfc0(13, 0);
    check("rst_cause", bus.rdata_o, 32'h0);
    mfc0(15, 1);
    check("rst_ebase", bus.rdata_o, 32'h8000_0000);
    mfc0(11, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
